// File: rtl/cache_fill_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl_param
// Brief    : Parametrised cache-block fill controller: one read request per
//            cycle per block word, in-order data-array writes, tag write at end.
// Options  : define CRITICAL_WORD_FIRST_EN to start the fill at the missed word
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_ctrl_param #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_BLK  = 8,
    parameter int BYTES_PER_WORD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              arb_force_reset,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] cache_wr_address,
    output logic [DATA_W-1:0] cache_wr_data,
    output logic              write_tag_array,
    output logic              EOB,
    output logic              fill_done
);

    localparam int c_OFF_W  = $clog2(WORDS_PER_BLK * BYTES_PER_WORD);
    localparam int c_IDX_W  = $clog2(WORDS_PER_BLK);
    localparam int c_CNT_W  = $clog2(WORDS_PER_BLK) + 1;
    localparam int c_BYTE_W = $clog2(BYTES_PER_WORD);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TAG   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_base;
    logic [c_CNT_W-1:0] r_iss_cnt;
    logic [c_CNT_W-1:0] r_rcv_cnt;
    logic [c_IDX_W-1:0] w_start;
    logic [c_CNT_W-1:0] w_iss_cnt_eff;
    logic [c_IDX_W-1:0] w_iss_idx;
    logic [c_IDX_W-1:0] w_rcv_idx;
    logic [ADDR_W-1:0]  w_iss_addr;
    logic [ADDR_W-1:0]  w_rcv_addr;
    logic               w_accept;
    logic               w_active;
    logic               w_abort;
    logic               w_wr;
    logic               w_last_rcv;
    logic               w_last_iss;
    logic               w_unused_low_addr;

    // Low address bits only matter for the start word; base drops them.
    assign w_unused_low_addr = ^miss_address[c_OFF_W-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    logic [c_IDX_W-1:0] r_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= '0;
        end else if (w_accept) begin
            r_start <= miss_address[c_OFF_W-1:c_BYTE_W];
        end
    end

    assign w_start = r_start;
`else
    assign w_start = '0;
`endif

    assign w_accept   = (r_state == ST_IDLE) && miss_detected && !arb_force_reset;
    assign w_active   = (r_state == ST_FILL) || (r_state == ST_DRAIN);
    assign w_abort    = w_active && (arb_force_reset || !miss_detected);
    assign w_wr       = w_active && memory_data_valid;
    assign w_last_rcv = w_wr && (r_rcv_cnt == c_LAST);
    assign w_last_iss = (r_state == ST_FILL) && (r_iss_cnt == c_LAST);

    // In DRAIN the issue counter has already stepped past the final request.
    assign w_iss_cnt_eff = (r_state == ST_DRAIN) ? (r_iss_cnt - c_CNT_W'(1)) : r_iss_cnt;
    assign w_iss_idx     = w_start + w_iss_cnt_eff[c_IDX_W-1:0];
    assign w_rcv_idx     = w_start + r_rcv_cnt[c_IDX_W-1:0];
    assign w_iss_addr    = r_base + (ADDR_W'(w_iss_idx) << c_BYTE_W);
    assign w_rcv_addr    = r_base + (ADDR_W'(w_rcv_idx) << c_BYTE_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_base    <= {miss_address[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                r_iss_cnt <= '0;
                r_rcv_cnt <= '0;
            end else if (w_abort) begin
                r_iss_cnt <= '0;
                r_rcv_cnt <= '0;
            end else begin
                if (r_state == ST_FILL) begin
                    r_iss_cnt <= r_iss_cnt + c_CNT_W'(1);
                end
                if (w_wr) begin
                    r_rcv_cnt <= r_rcv_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        mem_req          = 1'b0;
        memory_address   = '0;
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        cache_wr_address = '0;
        cache_wr_data    = '0;
        write_tag_array  = 1'b0;
        EOB              = 1'b0;
        fill_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL, ST_DRAIN: begin
                fsm_busy         = 1'b1;
                memory_address   = w_iss_addr;
                write_data_array = memory_data_valid;
                cache_wr_address = w_rcv_addr;
                cache_wr_data    = memory_data;
                if (r_state == ST_FILL) begin
                    mem_req = 1'b1;
                    EOB     = w_last_iss;
                end
                // Abort wins over completion; the final word of a zero-latency
                // memory can arrive while still issuing.
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_rcv) begin
                    w_next_state = ST_TAG;
                end else if (w_last_iss) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                fill_done       = 1'b1;
                w_next_state    = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/cache_fill_ctrl_param.md
Name: cache_fill_ctrl_param

Overview:
- Parametrised cache-block fill controller; successor to the fixed 8-word, 16-bit fill FSM.
- On a cache miss it issues one memory read request per cycle for every word of the block, counts in-order returning data, and writes each word into the data array.
- On the last word it pulses the tag-array write.
- Sits between the cache miss logic, the memory arbiter and the cache data/tag arrays; supports abort by the arbiter or by miss withdrawal.

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 16, memory/cache word width in bits
WORDS_PER_BLK, 8, words per cache block; power of two, 2..64
BYTES_PER_WORD, 2, address stride per word; power of two
(derived) OFF_W = log2(WORDS_PER_BLK*BYTES_PER_WORD); CNT_W = log2(WORDS_PER_BLK)+1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
miss_detected  input  1  miss request from cache; must stay high for the whole fill
miss_address  input  ADDR_W  faulting address; sampled on acceptance
arb_force_reset  input  1  arbiter abort
memory_data_valid  input  1  returning read word valid, in request order
memory_data  input  DATA_W  returning read word
mem_req  output  1  read request strobe
memory_address  output  ADDR_W  read request address
fsm_busy  output  1  fill in progress
write_data_array  output  1  data-array write enable
cache_wr_address  output  ADDR_W  data-array write address
cache_wr_data  output  DATA_W  data-array write data; equals memory_data
write_tag_array  output  1  tag-array write, one-cycle pulse
EOB  output  1  one-cycle pulse in the cycle the last request issues
fill_done  output  1  one-cycle pulse, coincident with write_tag_array

Behaviour:
- State register and all counters are reset by rst_n low, asynchronously. Reset state is IDLE. All outputs are 0 during reset and in IDLE.
- States: IDLE, FILL (issuing), DRAIN (all issued, awaiting data), TAG.
- IDLE: when miss_detected=1 and arb_force_reset=0, latch base = miss_address with the low OFF_W bits cleared, clear iss_cnt/rcv_cnt, and go to FILL next cycle. This gives 1 cycle of latency from miss to the first request.
- FILL:
  - mem_req=1 and memory_address = base + iss_idx*BYTES_PER_WORD, where iss_idx = iss_cnt mod WORDS_PER_BLK.
  - iss_cnt increments every FILL cycle; there is no memory back-pressure.
  - When iss_cnt = WORDS_PER_BLK-1, EOB=1 and the next state is DRAIN.
- DRAIN: mem_req=0 and memory_address holds its last value.
- FILL or DRAIN, memory_data_valid=1:
  - write_data_array=1, combinational from valid.
  - cache_wr_address = base + rcv_idx*BYTES_PER_WORD.
  - rcv_cnt increments.
  - When this is the WORDS_PER_BLK-th word, the next state is TAG. This applies from FILL too, for zero-latency memories.
- memory_data_valid in IDLE or TAG is ignored: no write, no count.
- TAG: write_tag_array=1 and fill_done=1 for exactly one cycle, fsm_busy=1, then IDLE. A miss still asserted in the IDLE cycle starts a new fill; the cache is expected to have deasserted it.
- fsm_busy=1 in FILL, DRAIN and TAG.
- Abort: arb_force_reset=1, or miss_detected=0, in FILL or DRAIN → IDLE next cycle with counters cleared.
  - No tag write and no fill_done on abort.
  - A data write occurring in the abort cycle still happens.
  - Abort in TAG has no effect; the pulse completes.
- Address arithmetic is ADDR_W-bit modulo. Offsets never carry out of the block because base is aligned.
- rcv_cnt never exceeds WORDS_PER_BLK.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined:
  - Latch start = miss_address[OFF_W-1:log2(BYTES_PER_WORD)].
  - iss_idx = (start + iss_cnt) mod WORDS_PER_BLK and rcv_idx = (start + rcv_cnt) mod WORDS_PER_BLK, so requests and writes wrap around the block starting at the missed word.
  - EOB and completion are still count-based.
- Undefined: start is fixed at 0 and order is always ascending from base.

Test Plan:
- Defaults, miss at 0x1236, valid 2 cycles after each req → requests 0x1230,0x1232,...,0x123E over 8 cycles. EOB is on the 0x123E cycle. 8 writes go to 0x1230..0x123E, then write_tag_array=1 for 1 cycle, then IDLE with fsm_busy=0.
- CRITICAL_WORD_FIRST_EN, miss at 0x1236 → request/write order 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234. Tag pulse follows the 8th write.
- arb_force_reset high after the 3rd valid → IDLE next cycle. No tag write, no fill_done. The next miss restarts at word 0 with counters cleared.
- rst_n low mid-DRAIN, asynchronously → all outputs 0 immediately. Stray memory_data_valid after release produces no write.
- WORDS_PER_BLK=4, DATA_W=32, BYTES_PER_WORD=4, miss 0xAB1C → requests 0xAB10,0xAB14,0xAB18,0xAB1C. Zero-latency valid makes the tag pulse occur in the cycle after the last request.
